// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcodes, digit codes, FSM encodings and BCD helper for calc_sequencer
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;

    localparam logic [3:0] DIG_MINUS = 4'd10;
    localparam logic [3:0] DIG_BLANK = 4'd11;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LATCH = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_CONV  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Double-dabble correction: a digit of 5 or more would overflow after the shift.
    function automatic logic [3:0] dd_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - synchronise and debounce one active-low key, emit a one-cycle press pulse
module key_debounce #(
    parameter int DEB_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic key_ni,
    output logic level_o,
    output logic press_o
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Count consecutive cycles the synchronised key disagrees with the debounced level.
    always_comb begin
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // Synchroniser and debounce state; keys read as released out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b1;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= key_ni;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign press_o = press_q;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - key-driven add/sub/multiply sequencer with BCD digit output; CALC_LZB_EN enables leading-zero blanking
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int W          = 5,
    parameter int DEB_CYCLES = 50000
) (
    input  logic           CLOCK_50,
    input  logic           RESET_N,
    input  logic [2*W-1:0] SW,
    input  logic [2:0]     KEY,
    output logic [2*W-1:0] LEDR,
    output logic           NEG,
    output logic           BUSY,
    output logic [3:0]     DIG3,
    output logic [3:0]     DIG2,
    output logic [3:0]     DIG1,
    output logic [3:0]     DIG0
);
    localparam int RW   = 2 * W;
    localparam int CNTW = $clog2(RW + 1);
`ifdef CALC_LZB_EN
    localparam logic [3:0] DIG_RST_HI = DIG_BLANK;
`else
    localparam logic [3:0] DIG_RST_HI = 4'd0;
`endif

    logic [2:0] level, press, press_ev;
    logic       ev_valid;
    logic [1:0] ev_op;

    logic [2:0]      state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, mplier_q, mplier_d;
    logic [RW-1:0]   acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [RW-1:0]   res_q, res_d, sh_q, sh_d, conv_val;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [15:0]     bcd_q, bcd_d, bcd_adj, bcd_next;
    logic            neg_q, neg_d, conv_load;
    logic [RW-1:0]   ledr_q, ledr_d;
    logic            neg_out_q, neg_out_d;
    logic [15:0]     dig_q, dig_d;

    for (genvar k = 0; k < 3; k++) begin : g_key
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk_i  (CLOCK_50),
            .rst_ni (RESET_N),
            .key_ni (KEY[k]),
            .level_o(level[k]),
            .press_o(press[k])
        );
    end

    // A press is only trusted while its debounced level reads pressed.
    assign press_ev = press & ~level;
    assign ev_valid = |press_ev;
    assign ev_op    = press_ev[0] ? OP_ADD : (press_ev[1] ? OP_SUB : OP_MUL);

    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign bcd_adj  = {dd_adjust(bcd_q[15:12]), dd_adjust(bcd_q[11:8]),
                       dd_adjust(bcd_q[7:4]),   dd_adjust(bcd_q[3:0])};
    assign bcd_next = (bcd_adj << 1) | {15'd0, sh_q[RW-1]};

    // Map BCD digits to display codes; the sign always owns the top digit.
    function automatic logic [15:0] dig_codes(input logic [15:0] bcd, input logic neg);
        logic [15:0] d;
        d = bcd;
`ifdef CALC_LZB_EN
        if (bcd[15:12] == 4'd0) d[15:12] = DIG_BLANK;
        if (bcd[15:8] == 8'd0)  d[11:8]  = DIG_BLANK;
        if (bcd[15:4] == 12'd0) d[7:4]   = DIG_BLANK;
`endif
        if (neg) d[15:12] = DIG_MINUS;
        return d;
    endfunction

    // Sequencer next-state: capture, execute, convert, publish.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        sh_d      = sh_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ledr_d    = ledr_q;
        neg_out_d = neg_out_q;
        dig_d     = dig_q;
        conv_load = 1'b0;
        conv_val  = '0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ev_valid) begin
                    a_d     = SW[2*W-1:W];
                    b_d     = SW[W-1:0];
                    op_d    = ev_op;
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                mcand_d  = RW'(a_q);
                mplier_d = b_q;
                acc_d    = '0;
                cnt_d    = '0;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        neg_d     = 1'b0;
                        conv_val  = RW'(a_q) + RW'(b_q);
                        conv_load = 1'b1;
                    end
                    OP_SUB: begin
                        neg_d     = (a_q < b_q);
                        conv_val  = (a_q >= b_q) ? RW'(a_q) - RW'(b_q) : RW'(b_q) - RW'(a_q);
                        conv_load = 1'b1;
                    end
                    default: begin
                        neg_d    = 1'b0;
                        acc_d    = acc_sum;
                        mcand_d  = mcand_q << 1;
                        mplier_d = mplier_q >> 1;
                        cnt_d    = cnt_q + CNTW'(1);
                        if (cnt_q == CNTW'(W - 1)) begin
                            conv_val  = acc_sum;
                            conv_load = 1'b1;
                        end
                    end
                endcase
            end
            ST_CONV: begin
                sh_d  = sh_q << 1;
                bcd_d = bcd_next;
                cnt_d = cnt_q + CNTW'(1);
                if (cnt_q == CNTW'(RW - 1)) begin
                    state_d   = ST_DONE;
                    ledr_d    = res_q;
                    neg_out_d = neg_q;
                    dig_d     = dig_codes(bcd_next, neg_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (conv_load) begin
            res_d   = conv_val;
            sh_d    = conv_val;
            bcd_d   = '0;
            cnt_d   = '0;
            state_d = ST_CONV;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            res_q     <= '0;
            sh_q      <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ledr_q    <= '0;
            neg_out_q <= 1'b0;
            dig_q     <= {DIG_RST_HI, DIG_RST_HI, DIG_RST_HI, 4'd0};
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
            sh_q      <= sh_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ledr_q    <= ledr_d;
            neg_out_q <= neg_out_d;
            dig_q     <= dig_d;
        end
    end

    assign BUSY = (state_q == ST_LATCH) || (state_q == ST_EXEC) || (state_q == ST_CONV);
    assign LEDR = ledr_q;
    assign NEG  = neg_out_q;
    assign DIG3 = dig_q[15:12];
    assign DIG2 = dig_q[11:8];
    assign DIG1 = dig_q[7:4];
    assign DIG0 = dig_q[3:0];

endmodule
